fp_result_pack_pipe: RTL and testbench
======================================

Name: fp_result_pack_pipe

Overview:
- Parametrised, pipelined successor to the combinational FP result-composition stage.
- Takes sign, extended biased exponent, and normalised mantissa with guard/round/sticky bits from the add/sub/mul/div datapaths.
- Rounds to nearest-even, classifies special cases (NaN, infinity, overflow, underflow flush-to-zero, zero) and packs an IEEE-style word.
- Two-stage pipeline with valid/ready backpressure and five-bit exception flags; sits between the ALU datapath and the ALU result register.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (hidden bit excluded)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_sign  input  1  result sign
in_exp  input  EXP_W+2  signed two's-complement biased exponent (bias 2^(EXP_W-1)-1)
in_man  input  MAN_W+4  [MAN_W+3]=hidden bit, [MAN_W+2:3]=fraction, [2]=G, [1]=R, [0]=S
in_exc_invalid  input  1  upstream invalid operation
in_exc_divzero  input  1  upstream divide by zero
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  EXP_W+MAN_W+1  packed {sign, exponent, fraction}
out_flags  output  5  {invalid, divzero, overflow, underflow, inexact}
flags_clr  input  1  clear sticky flags
sticky_flags  output  5  accumulated flags, same bit order as out_flags

Behaviour:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: out_valid=0, out_result=0, out_flags=0, sticky_flags=0, both internal stage valids=0. Reset mid-operation discards all in-flight beats.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv.
  - Beat accepted when in_valid & in_ready. Output transfers when out_valid & out_ready.
  - When adv=1 both stages shift together, with no bubbles collapsed independently (global stall). When adv=0 all stage registers and outputs hold.
- Latency: exactly 2 cycles from acceptance to out_valid when unstalled; throughput 1 beat/cycle.
- Stage 1, round (RNE):
  - lsb=in_man[3]; rup = G & (R | S | lsb); inexact_r = G | R | S.
  - m = in_man[MAN_W+3:3] + rup, computed as MAN_W+2 bits.
  - If m[MAN_W+1]=1 (carry out): m >>= 1, exp = in_exp + 1. Otherwise exp = in_exp.
  - Register sign, m, exp, inexact_r, exc_invalid and exc_divzero.
- Stage 2, classify and pack. Priority order, first match wins:
  1. invalid: result = {0, all-ones, 1 followed by zeros} (quiet NaN); flags = invalid only.
  2. divzero: result = {sign, all-ones, 0}; flags = divzero only.
  3. m == 0: result = {sign, 0, 0}; flags = 0.
  4. exp >= 2^EXP_W - 1: result = {sign, all-ones, 0}; flags = overflow | inexact.
  5. exp <= 0: flush to zero, result = {sign, 0, 0}; flags = underflow | inexact. No denormals are produced.
  6. Otherwise: result = {sign, exp[EXP_W-1:0], m[MAN_W-1:0]}; flags = inexact_r.
- out_flags is registered alongside out_result and is valid only with out_valid.
- Zero input with nonzero GRS (hidden=0) is treated as zero and its inexact is dropped. Upstream guarantees hidden=1 for every nonzero mantissa.

Optional Feature:
- FP_STICKY_FLAGS_EN defined:
  - On each clock, sticky_flags <= (flags_clr ? 0 : sticky_flags) | (out_valid & out_ready ? out_flags : 0).
  - If clear and transfer coincide, the transferring beat's flags survive.
- FP_STICKY_FLAGS_EN undefined: sticky_flags is tied to 0, flags_clr is ignored, and no sticky register is built.

Test Plan (EXP_W=8, MAN_W=23):
- sign=0, exp=127, hidden=1, frac=0, GRS=000 → out_result=0x3F800000, flags=0, out_valid exactly 2 cycles after acceptance.
- exp=127, frac=0x7FFFFF, GRS=100 → carry on round → 0x40000000, flags=00001. Separately, frac=0, GRS=100 (tie, even lsb) → 0x3F800000, flags=00001.
- Exponent boundaries:
  - exp=255, frac=0 → 0x7F800000, flags=00101.
  - sign=1, exp=0 → 0x80000000, flags=00011.
  - exp=254, frac=0x7FFFFF, GRS=110 → rounds into overflow → 0x7F800000, flags=00101.
- Special-case priority:
  - invalid=1 and divzero=1 → 0x7FC00000, flags=10000.
  - divzero=1, sign=1 → 0xFF800000, flags=01000.
  - man=0, sign=1 → 0x80000000, flags=0.
- Backpressure:
  - Stream 4 beats with out_ready=0 for cycles 3-5; in_ready falls while out_valid=1 & out_ready=0.
  - out_result holds stable throughout the stall; all 4 results arrive in order with none lost or duplicated.
  - Assert rst mid-stream → out_valid=0 next cycle.
- With FP_STICKY_FLAGS_EN: an overflow beat then an inexact beat → sticky=00101. flags_clr asserted on the same cycle as an invalid beat transfers → sticky=10000. Without the macro, sticky stays 0.

Source files
------------

// File: rtl/fp_result_pack_pipe.sv
// Two-stage round-to-nearest-even and IEEE pack stage with valid/ready backpressure.
// Optional sticky exception accumulator enabled by defining FP_STICKY_FLAGS_EN.
module fp_result_pack_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W+1:0]         in_exp,
  input  logic [MAN_W+3:0]         in_man,
  input  logic                     in_exc_invalid,
  input  logic                     in_exc_divzero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [4:0]               out_flags,
  input  logic                     flags_clr,
  output logic [4:0]               sticky_flags
);

  localparam int RES_W = EXP_W + MAN_W + 1;
  localparam int XE_W  = EXP_W + 3;
  localparam logic [XE_W-2:0] EXP_ALL1 = (XE_W-1)'((2 ** EXP_W) - 1);

  logic              adv;
  logic              rup;
  logic [MAN_W+1:0]  m_sum;
  logic [XE_W-1:0]   exp_ext;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q, s1_sign_d;
  logic [MAN_W:0]    s1_man_q, s1_man_d;
  logic [XE_W-1:0]   s1_exp_q, s1_exp_d;
  logic              s1_inexact_q, s1_inexact_d;
  logic              s1_inv_q, s1_inv_d;
  logic              s1_dz_q, s1_dz_d;
  logic              s1_zero_q, s1_zero_d;

  logic              ovf_c, unf_c;
  logic [RES_W-1:0]  res_c;
  logic [4:0]        flags_c;

  logic              out_valid_q, out_valid_d;
  logic [RES_W-1:0]  out_result_q, out_result_d;
  logic [4:0]        out_flags_q, out_flags_d;

  // Global stall: both stages advance together or hold together.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    rup     = in_man[2] & (in_man[1] | in_man[0] | in_man[3]);
    m_sum   = {1'b0, in_man[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, rup};
    exp_ext = {in_exp[EXP_W+1], in_exp};

    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_man_d     = s1_man_q;
    s1_exp_d     = s1_exp_q;
    s1_inexact_d = s1_inexact_q;
    s1_inv_d     = s1_inv_q;
    s1_dz_d      = s1_dz_q;
    s1_zero_d    = s1_zero_q;
    if (adv) begin
      s1_valid_d   = in_valid;
      s1_sign_d    = in_sign;
      s1_inexact_d = in_man[2] | in_man[1] | in_man[0];
      s1_inv_d     = in_exc_invalid;
      s1_dz_d      = in_exc_divzero;
      // Zero is judged on the unrounded significand so GRS debris cannot revive it.
      s1_zero_d    = (in_man[MAN_W+3:3] == '0);
      if (m_sum[MAN_W+1]) begin
        s1_man_d = m_sum[MAN_W+1:1];
        s1_exp_d = exp_ext + XE_W'(1);
      end else begin
        s1_man_d = m_sum[MAN_W:0];
        s1_exp_d = exp_ext;
      end
    end
  end

  always_comb begin
    ovf_c   = !s1_exp_q[XE_W-1] && (s1_exp_q[XE_W-2:0] >= EXP_ALL1);
    unf_c   = s1_exp_q[XE_W-1] || (s1_exp_q == '0);
    res_c   = {s1_sign_q, s1_exp_q[EXP_W-1:0], s1_man_q[MAN_W-1:0]};
    flags_c = {4'b0000, s1_inexact_q};
    if (s1_inv_q) begin
      res_c   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_c = 5'b10000;
    end else if (s1_dz_q) begin
      res_c   = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c = 5'b01000;
    end else if (s1_zero_q) begin
      res_c   = {s1_sign_q, {(RES_W-1){1'b0}}};
      flags_c = 5'b00000;
    end else if (ovf_c) begin
      res_c   = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c = 5'b00101;
    end else if (unf_c) begin
      res_c   = {s1_sign_q, {(RES_W-1){1'b0}}};
      flags_c = 5'b00011;
    end

    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    if (adv) begin
      out_valid_d  = s1_valid_q;
      out_result_d = res_c;
      out_flags_d  = flags_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_man_q     <= '0;
      s1_exp_q     <= '0;
      s1_inexact_q <= 1'b0;
      s1_inv_q     <= 1'b0;
      s1_dz_q      <= 1'b0;
      s1_zero_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_man_q     <= s1_man_d;
      s1_exp_q     <= s1_exp_d;
      s1_inexact_q <= s1_inexact_d;
      s1_inv_q     <= s1_inv_d;
      s1_dz_q      <= s1_dz_d;
      s1_zero_q    <= s1_zero_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

`ifdef FP_STICKY_FLAGS_EN
  logic [4:0] sticky_q, sticky_d;

  // A clear coinciding with a transfer still keeps the transferring beat's flags.
  always_comb begin
    sticky_d = (flags_clr ? 5'b00000 : sticky_q) |
               ((out_valid_q && out_ready) ? out_flags_q : 5'b00000);
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
  assign sticky_flags     = 5'b00000;
`endif

endmodule

// File: tb/tb_fp_result_pack_pipe.sv
// Directed self-checking bench for fp_result_pack_pipe (EXP_W=8, MAN_W=23).
module tb_fp_result_pack_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [26:0] in_man;
  logic        in_exc_invalid;
  logic        in_exc_divzero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  logic        flags_clr;
  logic [4:0]  sticky_flags;

  int checks   = 0;
  int failures = 0;

  fp_result_pack_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
    .in_exc_invalid(in_exc_invalid), .in_exc_divzero(in_exc_divzero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .flags_clr(flags_clr), .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] mk(input logic hid, input logic [22:0] frac, input logic [2:0] grs);
    return {hid, frac, grs};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Entered #1 after a rising edge; leaves the result sitting on the output.
  task automatic run_beat(input string tag, input logic s, input logic [9:0] e, input logic [26:0] m,
                          input logic inv, input logic dz, input logic [31:0] exp_res, input logic [4:0] exp_fl);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_man = m;
    in_exc_invalid = inv; in_exc_divzero = dz; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_exc_invalid = 1'b0; in_exc_divzero = 1'b0;
    check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_lat2"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_res"}, out_result, exp_res);
    check({tag, "_flg"}, {27'd0, out_flags}, {27'd0, exp_fl});
  endtask

  initial begin
    logic [31:0] prev_res;
    logic        prev_stall;
    int          sent, got, stalls;

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_man = '0;
    in_exc_invalid = 1'b0; in_exc_divzero = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_flags", {27'd0, out_flags}, 32'd0);
    check("rst_sticky", {27'd0, sticky_flags}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_beat("one",       1'b0, 10'd127, mk(1'b1, 23'h000000, 3'b000), 1'b0, 1'b0, 32'h3F800000, 5'b00000);
    run_beat("carry",     1'b0, 10'd127, mk(1'b1, 23'h7FFFFF, 3'b100), 1'b0, 1'b0, 32'h40000000, 5'b00001);
    run_beat("tie_even",  1'b0, 10'd127, mk(1'b1, 23'h000000, 3'b100), 1'b0, 1'b0, 32'h3F800000, 5'b00001);
    run_beat("tie_odd",   1'b0, 10'd127, mk(1'b1, 23'h000001, 3'b100), 1'b0, 1'b0, 32'h3F800002, 5'b00001);
    run_beat("exp255",    1'b0, 10'd255, mk(1'b1, 23'h000000, 3'b000), 1'b0, 1'b0, 32'h7F800000, 5'b00101);
    run_beat("exp0",      1'b1, 10'd0,   mk(1'b1, 23'h000000, 3'b000), 1'b0, 1'b0, 32'h80000000, 5'b00011);
    run_beat("exp_neg",   1'b0, 10'h3FB, mk(1'b1, 23'h123456, 3'b000), 1'b0, 1'b0, 32'h00000000, 5'b00011);
    run_beat("exp1",      1'b0, 10'd1,   mk(1'b1, 23'h000000, 3'b000), 1'b0, 1'b0, 32'h00800000, 5'b00000);
    run_beat("rnd_ovf",   1'b0, 10'd254, mk(1'b1, 23'h7FFFFF, 3'b110), 1'b0, 1'b0, 32'h7F800000, 5'b00101);
    run_beat("inv_dz",    1'b1, 10'd127, mk(1'b1, 23'h000000, 3'b000), 1'b1, 1'b1, 32'h7FC00000, 5'b10000);
    run_beat("divzero",   1'b1, 10'd127, mk(1'b1, 23'h000000, 3'b000), 1'b0, 1'b1, 32'hFF800000, 5'b01000);
    run_beat("zero",      1'b1, 10'd127, mk(1'b0, 23'h000000, 3'b000), 1'b0, 1'b0, 32'h80000000, 5'b00000);
    run_beat("zero_grs",  1'b0, 10'd127, mk(1'b0, 23'h000000, 3'b110), 1'b0, 1'b0, 32'h00000000, 5'b00000);

    // Drain the last result, then stream four beats through a stall.
    @(posedge clk); #1;
    sent = 0; got = 0; stalls = 0; prev_stall = 1'b0; prev_res = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in_valid = (sent < 4);
      in_sign = 1'b0; in_exp = 10'd127; in_man = mk(1'b1, 23'(sent + 1), 3'b000);
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (prev_stall) begin
        check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold_res", out_result, prev_res);
      end
      if (out_valid && !out_ready) begin
        stalls++;
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) begin
        if (got < 4) check("stream_order", out_result, 32'h3F800000 + 32'(got + 1));
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    check("stream_count", 32'(got), 32'd4);
    check("stall_cycles", 32'(stalls), 32'd3);

    // Reset in the middle of a stream discards everything in flight.
    out_ready = 1'b1;
    in_valid = 1'b1; in_exp = 10'd127; in_man = mk(1'b1, 23'h000005, 3'b000);
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sticky", {27'd0, sticky_flags}, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("midrst_flushed", {31'd0, out_valid}, 32'd0);

    // Sticky accumulation and clear.
    run_beat("stk_ovf", 1'b0, 10'd255, mk(1'b1, 23'h000000, 3'b000), 1'b0, 1'b0, 32'h7F800000, 5'b00101);
    run_beat("stk_inx", 1'b0, 10'd127, mk(1'b1, 23'h000000, 3'b100), 1'b0, 1'b0, 32'h3F800000, 5'b00001);
    @(posedge clk); #1;
`ifdef FP_STICKY_FLAGS_EN
    check("sticky_accum", {27'd0, sticky_flags}, 32'h05);
`else
    check("sticky_accum", {27'd0, sticky_flags}, 32'h00);
`endif
    run_beat("stk_inv", 1'b0, 10'd127, mk(1'b1, 23'h000000, 3'b000), 1'b1, 1'b0, 32'h7FC00000, 5'b10000);
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
`ifdef FP_STICKY_FLAGS_EN
    check("sticky_clr_xfer", {27'd0, sticky_flags}, 32'h10);
`else
    check("sticky_clr_xfer", {27'd0, sticky_flags}, 32'h00);
`endif
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    check("sticky_clr", {27'd0, sticky_flags}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
